// File: rtl/seq_mlp_pkg.sv
// Shared definitions for the sequential MLP engine.
//   state_t        : controller states
//   out_width      : width of the class-index output, at least one bit
//   cnt_width      : width of the shared neuron/input counters
//   weight_offset  : bit offset of w(neuron, src) inside the flat weight bus
//   bias_offset    : bit offset of b(neuron) inside the flat bias bus
package seq_mlp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int out_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    // Counters never exceed (largest dimension - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Layer 0: w(j,i) for hidden neuron j and input i.
    // Layer 1: w(k,j) for class k and hidden neuron j, stored after all layer-0 weights.
    function automatic int weight_offset(input int layer, input int neuron, input int src,
                                         input int n_in, input int n_hid, input int w_w);
        if (layer == 0) begin
            return (neuron * n_in + src) * w_w;
        end
        return (n_in * n_hid + neuron * n_hid + src) * w_w;
    endfunction

    function automatic int bias_offset(input int layer, input int neuron, input int n_hid,
                                       input int b0_w, input int b1_w);
        if (layer == 0) begin
            return neuron * b0_w;
        end
        return n_hid * b0_w + neuron * b1_w;
    endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Multiply-accumulate slice used once per MLP layer.
//   clk, rst  : clock, synchronous active-high reset
//   en        : accumulate this cycle
//   load      : first product of a neuron; start from the bias instead of the accumulator
//   operand   : unsigned activation (zero-extended)
//   weight    : signed weight (sign-extended)
//   bias      : bias already sign-extended to ACC_W
//   relu_sum  : ReLU of the sum being formed this cycle (valid while en=1)
module mlp_mac_unit #(
    parameter int OP_W  = 4,
    parameter int W_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [OP_W-1:0]      operand,
    input  logic [W_W-1:0]       weight,
    input  logic [ACC_W-1:0]     bias,
    output logic [ACC_W-2:0]     relu_sum
);

    logic        [ACC_W-1:0] acc_reg;
    logic        [ACC_W-1:0] acc_next;
    logic signed [W_W-1:0]   weight_s;
    logic signed [ACC_W-1:0] op_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;

    assign weight_s = weight;
    assign op_ext   = ACC_W'(operand);
    assign w_ext    = ACC_W'(weight_s);
    // Product kept at accumulator width: everything wraps modulo 2^ACC_W anyway.
    assign prod     = op_ext * w_ext;
    assign acc_next = (load ? bias : acc_reg) + prod;
    assign relu_sum = acc_next[ACC_W-1] ? '0 : acc_next[ACC_W-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/seq_mlp_engine.sv
// Time-multiplexed two-layer ReLU MLP classifier, one product per clock.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : sample, weights and biases presented
//   in_ready   : engine idle (low while rst is high)
//   inp        : N_IN unsigned features, IN_W bits each
//   weights    : layer-0 then layer-1 signed weights, W_W bits each
//   biases     : layer-0 (B0_W) then layer-1 (B1_W) signed biases
//   out_valid  : class index held on out
//   out_ready  : sink takes the result
//   out        : argmax class index, ties to the lowest index
module seq_mlp_engine
    import seq_mlp_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_HID  = 3,
    parameter int N_OUT  = 3,
    parameter int IN_W   = 4,
    parameter int W_W    = 8,
    parameter int B0_W   = 11,
    parameter int B1_W   = 17,
    parameter int ACC0_W = 16,
    parameter int ACC1_W = 24
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [N_IN*IN_W-1:0]                      inp,
    input  logic [(N_IN*N_HID+N_HID*N_OUT)*W_W-1:0]   weights,
    input  logic [N_HID*B0_W+N_OUT*B1_W-1:0]          biases,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [out_width(N_OUT)-1:0]               out
);

    localparam int OUT_W = out_width(N_OUT);
    localparam int CNT_W = cnt_width(N_IN, N_HID, N_OUT);
    localparam int HID_W = ACC0_W - 1;
    localparam int Y_W   = ACC1_W - 1;

    state_t state_reg, state_next;

    logic [N_IN*IN_W-1:0]                    inp_reg;
    logic [(N_IN*N_HID+N_HID*N_OUT)*W_W-1:0] weights_reg;
    logic [N_HID*B0_W+N_OUT*B1_W-1:0]        biases_reg;

    // outer: neuron j in L0, class k in L1; inner: input i in L0, hidden j in L1
    logic [CNT_W-1:0] outer_reg, inner_reg;
    logic             inner_last, outer_last;
    logic             accept;

    logic [HID_W-1:0] hid_reg [N_HID];
    logic [Y_W-1:0]   best_reg, best_next;
    logic [OUT_W-1:0] idx_reg, idx_next, out_reg;
    logic             take;

    // Fixed slices of the captured buses
    logic [IN_W-1:0] x_arr  [N_IN];
    logic [W_W-1:0]  w0_arr [N_HID][N_IN];
    logic [W_W-1:0]  w1_arr [N_OUT][N_HID];
    logic [B0_W-1:0] b0_arr [N_HID];
    logic [B1_W-1:0] b1_arr [N_OUT];

    logic [IN_W-1:0]   x_sel;
    logic [HID_W-1:0]  hid_sel;
    logic [W_W-1:0]    w0_sel, w1_sel;
    logic [B0_W-1:0]   b0_sel;
    logic [B1_W-1:0]   b1_sel;
    logic [ACC0_W-1:0] b0_ext;
    logic [ACC1_W-1:0] b1_ext;
    logic [HID_W-1:0]  relu0;
    logic [Y_W-1:0]    relu1;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
        assign x_arr[gi] = inp_reg[gi*IN_W +: IN_W];
    end

    for (genvar gi = 0; gi < N_HID; gi++) begin : g_l0
        assign b0_arr[gi] = biases_reg[bias_offset(0, gi, N_HID, B0_W, B1_W) +: B0_W];
        for (genvar gj = 0; gj < N_IN; gj++) begin : g_w0
            assign w0_arr[gi][gj] = weights_reg[weight_offset(0, gi, gj, N_IN, N_HID, W_W) +: W_W];
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_l1
        assign b1_arr[gi] = biases_reg[bias_offset(1, gi, N_HID, B0_W, B1_W) +: B1_W];
        for (genvar gj = 0; gj < N_HID; gj++) begin : g_w1
            assign w1_arr[gi][gj] = weights_reg[weight_offset(1, gi, gj, N_IN, N_HID, W_W) +: W_W];
        end
    end

    // Counter-driven operand muxes (compare-based so no index ever goes out of range)
    always_comb begin
        x_sel   = '0;
        hid_sel = '0;
        w0_sel  = '0;
        w1_sel  = '0;
        b0_sel  = '0;
        b1_sel  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (inner_reg == CNT_W'(i)) x_sel = x_arr[i];
        end
        for (int j = 0; j < N_HID; j++) begin
            if (outer_reg == CNT_W'(j)) b0_sel = b0_arr[j];
            if (inner_reg == CNT_W'(j)) hid_sel = hid_reg[j];
            for (int i = 0; i < N_IN; i++) begin
                if (outer_reg == CNT_W'(j) && inner_reg == CNT_W'(i)) w0_sel = w0_arr[j][i];
            end
        end
        for (int k = 0; k < N_OUT; k++) begin
            if (outer_reg == CNT_W'(k)) b1_sel = b1_arr[k];
            for (int j = 0; j < N_HID; j++) begin
                if (outer_reg == CNT_W'(k) && inner_reg == CNT_W'(j)) w1_sel = w1_arr[k][j];
            end
        end
    end

    assign b0_ext = ACC0_W'(signed'(b0_sel));
    assign b1_ext = ACC1_W'(signed'(b1_sel));

    mlp_mac_unit #(.OP_W(IN_W), .W_W(W_W), .ACC_W(ACC0_W)) u_mac0 (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg == L0),
        .load     (inner_reg == '0),
        .operand  (x_sel),
        .weight   (w0_sel),
        .bias     (b0_ext),
        .relu_sum (relu0)
    );

    mlp_mac_unit #(.OP_W(HID_W), .W_W(W_W), .ACC_W(ACC1_W)) u_mac1 (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg == L1),
        .load     (inner_reg == '0),
        .operand  (hid_sel),
        .weight   (w1_sel),
        .bias     (b1_ext),
        .relu_sum (relu1)
    );

    always_comb begin
        inner_last = 1'b0;
        outer_last = 1'b0;
        if (state_reg == L0) begin
            inner_last = (inner_reg == CNT_W'(N_IN - 1));
            outer_last = (outer_reg == CNT_W'(N_HID - 1));
        end else if (state_reg == L1) begin
            inner_last = (inner_reg == CNT_W'(N_HID - 1));
            outer_last = (outer_reg == CNT_W'(N_OUT - 1));
        end
    end

    // Running argmax; class 0 always seeds it, later classes need a strict win.
    assign take      = (outer_reg == '0) || (relu1 > best_reg);
    assign best_next = take ? relu1 : best_reg;
    assign idx_next  = take ? OUT_W'(outer_reg) : idx_reg;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_next = L0;
            end
            L0: begin
                if (inner_last && outer_last) state_next = L1;
            end
            L1: begin
                if (inner_last && outer_last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign out    = out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outer_reg <= '0;
            inner_reg <= '0;
            best_reg  <= '0;
            idx_reg   <= '0;
            out_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        outer_reg <= '0;
                        inner_reg <= '0;
                    end
                end
                L0, L1: begin
                    if (inner_last) begin
                        inner_reg <= '0;
                        outer_reg <= outer_last ? '0 : outer_reg + CNT_W'(1);
                    end else begin
                        inner_reg <= inner_reg + CNT_W'(1);
                    end
                    if (state_reg == L1 && inner_last) begin
                        best_reg <= best_next;
                        idx_reg  <= idx_next;
                        if (outer_last) out_reg <= idx_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand capture: the engine works only from these copies after acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            inp_reg     <= inp;
            weights_reg <= weights;
            biases_reg  <= biases;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_HID; j++) hid_reg[j] <= '0;
        end else if (state_reg == L0 && inner_last) begin
            for (int j = 0; j < N_HID; j++) begin
                if (outer_reg == CNT_W'(j)) hid_reg[j] <= relu0;
            end
        end
    end

endmodule

// File: tb/tb_seq_mlp_engine.sv
// Bench for seq_mlp_engine: default build plus an 8-5-4 build, checked against
// a behavioural network model evaluated with plain integer arithmetic.
module tb_seq_mlp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default build 4-3-3
    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [15:0]  s_inp;
    logic [167:0] s_weights;
    logic [83:0]  s_biases;
    logic [1:0]   s_out;

    // wide build 8-5-4
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]  b_inp;
    logic [479:0] b_weights;
    logic [122:0] b_biases;
    logic [1:0]   b_out;

    seq_mlp_engine u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .inp(s_inp), .weights(s_weights), .biases(s_biases),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out)
    );

    seq_mlp_engine #(.N_IN(8), .N_HID(5), .N_OUT(4)) u_big (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .inp(b_inp), .weights(b_weights), .biases(b_biases),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
    );

    int checks = 0;
    int passed = 0;

    // network under test, max dimensions
    int x  [8];
    int w0 [5][8];
    int w1 [4][5];
    int b0 [5];
    int b1 [4];

    logic [479:0] pk_w;
    logic [122:0] pk_b;
    logic [31:0]  pk_x;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = longint'(1) << w;
        v = v & (m - 1);
        if (v >= (m >> 1)) v = v - m;
        return v;
    endfunction

    // Full-precision sums, wrapped once at the accumulator width, then ReLU and argmax.
    function automatic int model(input int ni, input int nh, input int no);
        longint acc, y, best;
        longint hid [5];
        int idx;
        best = 0;
        idx  = 0;
        for (int j = 0; j < nh; j++) begin
            acc = b0[j];
            for (int i = 0; i < ni; i++) acc += longint'(x[i]) * w0[j][i];
            acc = wrap(acc, 16);
            hid[j] = (acc < 0) ? 0 : acc;
        end
        for (int k = 0; k < no; k++) begin
            acc = b1[k];
            for (int j = 0; j < nh; j++) acc += hid[j] * w1[k][j];
            acc = wrap(acc, 24);
            y = (acc < 0) ? 0 : acc;
            if (k == 0 || y > best) begin
                best = y;
                idx  = k;
            end
        end
        return idx;
    endfunction

    task automatic pack(input int ni, input int nh, input int no);
        logic [3:0]  t4;
        logic [7:0]  t8;
        logic [10:0] t11;
        logic [16:0] t17;
        pk_w = '0;
        pk_b = '0;
        pk_x = '0;
        for (int i = 0; i < ni; i++) begin
            t4 = 4'(x[i]);
            pk_x[i*4 +: 4] = t4;
        end
        for (int j = 0; j < nh; j++) begin
            for (int i = 0; i < ni; i++) begin
                t8 = 8'(w0[j][i]);
                pk_w[(j*ni + i)*8 +: 8] = t8;
            end
            t11 = 11'(b0[j]);
            pk_b[j*11 +: 11] = t11;
        end
        for (int k = 0; k < no; k++) begin
            for (int j = 0; j < nh; j++) begin
                t8 = 8'(w1[k][j]);
                pk_w[(ni*nh + k*nh + j)*8 +: 8] = t8;
            end
            t17 = 17'(b1[k]);
            pk_b[nh*11 + k*17 +: 17] = t17;
        end
    endtask

    task automatic rand_vec(input int ni, input int nh, input int no);
        for (int i = 0; i < ni; i++) x[i] = int'($urandom_range(15));
        for (int j = 0; j < nh; j++) begin
            for (int i = 0; i < ni; i++) w0[j][i] = int'($urandom_range(255)) - 128;
            b0[j] = int'($urandom_range(2047)) - 1024;
        end
        for (int k = 0; k < no; k++) begin
            for (int j = 0; j < nh; j++) w1[k][j] = int'($urandom_range(255)) - 128;
            b1[k] = int'($urandom_range(131071)) - 65536;
        end
    endtask

    task automatic zero_weights();
        for (int j = 0; j < 5; j++) for (int i = 0; i < 8; i++) w0[j][i] = 0;
        for (int k = 0; k < 4; k++) for (int j = 0; j < 5; j++) w1[k][j] = 0;
    endtask

    // Present the current network to the default build and take the acceptance edge,
    // then drive junk on the ports to show the engine uses its captured copy.
    task automatic s_accept(input string tag);
        logic [191:0] r;
        pack(4, 3, 3);
        s_inp     = pk_x[15:0];
        s_weights = pk_w[167:0];
        s_biases  = pk_b[83:0];
        check({tag, "_in_ready"}, 32'(s_in_ready), 1);
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        s_weights = r[167:0];
        s_biases  = r[191:108];
        s_inp     = r[47:32];
    endtask

    task automatic s_finish(input string tag, input int want, input int stall);
        int cyc;
        cyc = 0;
        while (!s_out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 21);
        check({tag, "_out"}, 32'(s_out), want);
        for (int n = 0; n < stall; n++) begin
            s_in_valid = n[0];
            @(posedge clk); #1;
            check({tag, "_hold_out"}, 32'(s_out), want);
            check({tag, "_hold_valid"}, 32'(s_out_valid), 1);
            check({tag, "_hold_in_ready"}, 32'(s_in_ready), 0);
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(s_out_valid), 0);
        check({tag, "_post_in_ready"}, 32'(s_in_ready), 1);
    endtask

    task automatic run_small(input string tag, input int stall);
        int want;
        want = model(4, 3, 3);
        s_accept(tag);
        s_finish(tag, want, stall);
    endtask

    task automatic run_big(input string tag);
        int want, cyc;
        logic [479:0] r;
        want = model(8, 5, 4);
        pack(8, 5, 4);
        b_inp     = pk_x;
        b_weights = pk_w;
        b_biases  = pk_b;
        check({tag, "_in_ready"}, 32'(b_in_ready), 1);
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int n = 0; n < 15; n++) r[n*32 +: 32] = $urandom();
        b_weights = r;
        b_biases  = r[122:0];
        b_inp     = r[479:448];
        cyc = 0;
        while (!b_out_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 60);
        check({tag, "_out"}, 32'(b_out), want);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check({tag, "_post_in_ready"}, 32'(b_in_ready), 1);
    endtask

    initial begin
        int p_w0 [3][4];
        int p_w1 [3][3];
        int p_b0 [3];
        int p_b1 [3];

        rst = 1'b1;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_inp = '0; s_weights = '0; s_biases = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_inp = '0; b_weights = '0; b_biases = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(s_in_ready), 0);
        check("reset_out_valid", 32'(s_out_valid), 0);
        check("reset_out", 32'(s_out), 0);
        check("reset_big_out_valid", 32'(b_out_valid), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(s_in_ready), 1);

        // reference network with inp=0
        p_w0 = '{'{88, 86, -88, -86}, '{59, 57, -59, -59}, '{-12, -3, -6, -12}};
        p_w1 = '{'{-98, 72, 12}, '{1, 55, -4}, '{33, -72, 11}};
        p_b0 = '{-1, 571, -164};
        p_b1 = '{-38551, -33633, 33375};
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 4; i++) w0[j][i] = p_w0[j][i];
            b0[j] = p_b0[j];
            x[j] = 0;
        end
        x[3] = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) w1[k][j] = p_w1[k][j];
            b1[k] = p_b1[k];
        end
        run_small("plan", 0);
        check("plan_class0", 32'(s_out), 0);

        // bias-only networks: highest bias wins, ties go low
        rand_vec(4, 3, 3);
        zero_weights();
        b1[0] = 0; b1[1] = 0; b1[2] = 100;
        run_small("bias_hi", 0);
        check("bias_hi_class2", 32'(s_out), 2);

        // reset 10 cycles into a transaction, with out still holding 2
        rand_vec(4, 3, 3);
        s_accept("abort");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 32'(s_out_valid), 0);
        check("abort_out", 32'(s_out), 0);
        check("abort_in_ready", 32'(s_in_ready), 0);
        rst = 1'b0;
        #1;
        check("abort_idle_in_ready", 32'(s_in_ready), 1);
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_result", 32'(s_out_valid), 0);

        zero_weights();
        b1[0] = 7; b1[1] = 7; b1[2] = 0;
        run_small("bias_tie", 0);
        check("bias_tie_class0", 32'(s_out), 0);

        // stalled sink with in_valid pulses during DONE
        rand_vec(4, 3, 3);
        run_small("stall", 5);

        for (int n = 0; n < 20; n++) begin
            rand_vec(4, 3, 3);
            run_small($sformatf("rand%0d", n), 0);
        end

        for (int n = 0; n < 10; n++) begin
            rand_vec(8, 5, 4);
            run_big($sformatf("big%0d", n));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
